multicycle_cpu: RTL and testbench

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

---
 rtl/multicycle_cpu_if.sv | 21 ++
 rtl/multicycle_cpu.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_cpu_if.sv
// Memory bus between multicycle_cpu (master) and a memory/responder (slave).
interface multicycle_cpu_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB/TRAP over one shared memory bus.
// Optional build macro MULTICYCLE_CPU_OVF_TRAP_EN: signed overflow on add/addi/sub traps
// from EXEC without writeback; when undefined the result wraps and is written back.
module multicycle_cpu #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_cpu_if.master  bus,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       inst,
    output logic [31:0]       s0,
    output logic [2:0]        state,
    output logic              trap
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   r_alu;
    logic              r_trap;
    logic [XLEN-1:0]   r_regs [NREG];

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_rs_idx;
    logic [4:0]        w_rt_idx;
    logic [4:0]        w_rd_idx;
    logic [15:0]       w_imm16;
    logic [25:0]       w_imm26;
    logic [XLEN-1:0]   w_rs;
    logic [XLEN-1:0]   w_rt;
    logic [XLEN-1:0]   w_simm;
    logic [XLEN-1:0]   w_zimm;
    logic              w_legal;
    logic              w_is_jr;
    logic              w_xfer;
    logic [XLEN-1:0]   w_alu_res;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_br;
    logic [ADDR_W-1:0] w_pc_jmp;

    logic              w_pc_we;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_inst_we;
    logic              w_alu_we;
    logic [XLEN-1:0]   w_alu_nxt;
    logic              w_rf_we;
    logic [4:0]        w_rf_waddr;
    logic [XLEN-1:0]   w_rf_wdata;

    // Instruction field decode and operand fetch (r0 always reads as zero)
    assign w_op     = r_inst[31:26];
    assign w_rs_idx = r_inst[25:21];
    assign w_rt_idx = r_inst[20:16];
    assign w_rd_idx = r_inst[15:11];
    assign w_funct  = r_inst[5:0];
    assign w_imm16  = r_inst[15:0];
    assign w_imm26  = r_inst[25:0];
    assign w_rs     = (w_rs_idx == 5'd0) ? '0 : r_regs[w_rs_idx];
    assign w_rt     = (w_rt_idx == 5'd0) ? '0 : r_regs[w_rt_idx];
    assign w_simm   = {{16{w_imm16[15]}}, w_imm16};
    assign w_zimm   = {16'h0000, w_imm16};
    assign w_is_jr  = (w_op == OP_RTYPE) && (w_funct == FN_JR);
    assign w_xfer   = bus.mem_req & bus.mem_ack;

    assign w_pc_inc = r_pc + ADDR_W'(4);
    assign w_pc_br  = r_pc + ADDR_W'({w_simm[29:0], 2'b00});
    assign w_pc_jmp = ADDR_W'({w_imm26, 2'b00});

    assign w_legal = ((w_op == OP_RTYPE) &&
                      (w_funct == FN_ADD || w_funct == FN_SUB ||
                       w_funct == FN_SLT || w_funct == FN_JR)) ||
                     (w_op == OP_ADDI) || (w_op == OP_XORI) ||
                     (w_op == OP_LW)   || (w_op == OP_SW)   ||
                     (w_op == OP_J)    || (w_op == OP_JAL)  || (w_op == OP_BNE);

    // ALU: arithmetic, compare, and load/store effective address
    always_comb begin
        w_alu_res = '0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD:  w_alu_res = w_rs + w_rt;
                    FN_SUB:  w_alu_res = w_rs - w_rt;
                    FN_SLT:  w_alu_res = XLEN'($signed(w_rs) < $signed(w_rt));
                    default: w_alu_res = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: w_alu_res = w_rs + w_simm;
            OP_XORI:               w_alu_res = w_rs ^ w_zimm;
            default:               w_alu_res = '0;
        endcase
    end

`ifdef MULTICYCLE_CPU_OVF_TRAP_EN
    logic w_ovf;

    // Signed overflow detect for add/addi/sub
    always_comb begin
        w_ovf = 1'b0;
        if ((w_op == OP_ADDI) || ((w_op == OP_RTYPE) && (w_funct == FN_ADD))) begin
            w_ovf = (w_rs[31] == ((w_op == OP_ADDI) ? w_simm[31] : w_rt[31])) &&
                    (w_alu_res[31] != w_rs[31]);
        end else if ((w_op == OP_RTYPE) && (w_funct == FN_SUB)) begin
            w_ovf = (w_rs[31] != w_rt[31]) && (w_alu_res[31] != w_rs[31]);
        end
    end
`endif

    // Next-state and datapath control
    always_comb begin
        w_state_nxt = r_state;
        w_pc_we     = 1'b0;
        w_pc_nxt    = r_pc;
        w_inst_we   = 1'b0;
        w_alu_we    = 1'b0;
        w_alu_nxt   = w_alu_res;
        w_rf_we     = 1'b0;
        w_rf_waddr  = 5'd0;
        w_rf_wdata  = r_alu;
        case (r_state)
            ST_FETCH: begin
                if (w_xfer) begin
                    w_inst_we   = 1'b1;
                    w_pc_we     = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!w_legal) begin
                    w_state_nxt = ST_TRAP;
                end else if (w_op == OP_J || w_op == OP_JAL) begin
                    w_pc_we     = 1'b1;
                    w_pc_nxt    = w_pc_jmp;
                    w_rf_we     = (w_op == OP_JAL);
                    w_rf_waddr  = 5'd31;
                    w_rf_wdata  = XLEN'(r_pc);
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef MULTICYCLE_CPU_OVF_TRAP_EN
                if (w_ovf) begin
                    w_state_nxt = ST_TRAP;
                end else
`endif
                if (w_op == OP_BNE) begin
                    w_pc_we     = (w_rs != w_rt);
                    w_pc_nxt    = w_pc_br;
                    w_state_nxt = ST_FETCH;
                end else if (w_is_jr) begin
                    w_pc_we     = 1'b1;
                    w_pc_nxt    = w_rs[ADDR_W-1:0];
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_alu_we    = 1'b1;
                    w_state_nxt = (w_op == OP_LW || w_op == OP_SW) ? ST_MEM : ST_WB;
                end
            end
            ST_MEM: begin
                if (w_xfer) begin
                    w_alu_we    = (w_op == OP_LW);
                    w_alu_nxt   = bus.mem_rdata;
                    w_state_nxt = (w_op == OP_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                w_rf_we     = 1'b1;
                w_rf_waddr  = (w_op == OP_RTYPE) ? w_rd_idx : w_rt_idx;
                w_state_nxt = ST_FETCH;
            end
            ST_TRAP: w_state_nxt = ST_TRAP;
            default: w_state_nxt = ST_TRAP;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, instruction, ALU result, trap flag and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc   <= RESET_PC;
            r_inst <= '0;
            r_alu  <= '0;
            r_trap <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_trap <= (w_state_nxt == ST_TRAP);
            if (w_pc_we) begin
                r_pc <= w_pc_nxt;
            end
            if (w_inst_we) begin
                r_inst <= bus.mem_rdata;
            end
            if (w_alu_we) begin
                r_alu <= w_alu_nxt;
            end
            if (w_rf_we && (w_rf_waddr != 5'd0)) begin
                r_regs[w_rf_waddr] <= w_rf_wdata;
            end
        end
    end

    // Bus drive: requests only in FETCH/MEM, suppressed while reset is held
    assign bus.mem_req   = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !reset;
    assign bus.mem_we    = bus.mem_req && (r_state == ST_MEM) && (w_op == OP_SW);
    assign bus.mem_addr  = (r_state == ST_MEM) ? {r_alu[ADDR_W-1:2], 2'b00}
                                               : {r_pc[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = w_rt;

    assign pc    = r_pc;
    assign inst  = r_inst;
    assign s0    = r_regs[16];
    assign state = r_state;
    assign trap  = r_trap;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: ALU vector table plus hand-written
// sequences for load/store waits, jumps, branches, traps and reset abort.
module tb_multicycle_cpu;
    localparam int unsigned ADDR_W = 16;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
    logic [31:0]       s0;
    logic [2:0]        state;
    logic              trap;

    multicycle_cpu_if #(.ADDR_W(ADDR_W)) bus_if ();

    multicycle_cpu #(.ADDR_W(ADDR_W), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .pc    (pc),
        .inst  (inst),
        .s0    (s0),
        .state (state),
        .trap  (trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          ovf;
    } vec_t;

    logic [31:0] mem [0:16383];
    wr_t         wq[$];
    logic [15:0] fq[$];
    int          total = 0;
    int          bad   = 0;
    int          ack_delay = 0;
    int          n_wr40 = 0;
    bit          mem_auto = 1'b1;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // Memory responder with programmable ack delay; scoreboards writes and fetch addresses
    initial begin
        int          cnt = 0;
        bit          unstable = 1'b0;
        logic [15:0] s_addr = '0;
        logic        s_we = 1'b0;
        logic [31:0] s_wdata = '0;
        wr_t         w;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!mem_auto) begin
                bus_if.mem_ack   = man_ack;
                bus_if.mem_rdata = man_rdata;
                cnt = 0;
            end else if (bus_if.mem_req) begin
                if (cnt == 0) begin
                    s_addr = bus_if.mem_addr; s_we = bus_if.mem_we; s_wdata = bus_if.mem_wdata;
                end else if (bus_if.mem_addr !== s_addr || bus_if.mem_we !== s_we ||
                             (s_we && bus_if.mem_wdata !== s_wdata)) begin
                    unstable = 1'b1;
                end
                if (cnt >= ack_delay) begin
                    if (cnt > 0) chk("bus_stable", 32'(unstable), 32'd0);
                    unstable = 1'b0;
                    bus_if.mem_ack   = 1'b1;
                    bus_if.mem_rdata = mem[bus_if.mem_addr[15:2]];
                    if (bus_if.mem_we) begin
                        mem[bus_if.mem_addr[15:2]] = bus_if.mem_wdata;
                        if (bus_if.mem_addr == 16'h0040) n_wr40++;
                        if (wq.size() == 0) begin
                            chk("unexpected_write_addr", 32'(bus_if.mem_addr), 32'hFFFF_FFFF);
                        end else begin
                            w = wq.pop_front();
                            chk("wr_addr", 32'(bus_if.mem_addr), 32'(w.addr));
                            chk("wr_data", bus_if.mem_wdata, w.data);
                        end
                    end else if (state == 3'd0 && fq.size() > 0) begin
                        chk("fetch_addr", 32'(bus_if.mem_addr), 32'(fq.pop_front()));
                    end
                    cnt = 0;
                end else begin
                    bus_if.mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                if (cnt > 0 && !reset) chk("req_held", 32'(bus_if.mem_req), 32'd1);
                bus_if.mem_ack = 1'b0;
                cnt = 0;
                unstable = 1'b0;
            end
        end
    end

    // Reset, check reset state, then clear memory and scoreboards
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_inst", inst, 32'h0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_trap", 32'(trap), 32'd0);
        chk("reset_s0", s0, 32'h0);
        chk("reset_req", 32'(bus_if.mem_req), 32'd0);
        wq.delete();
        fq.delete();
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        ack_delay = 0;
        n_wr40 = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Run until both scoreboards drain (and at least min_cyc cycles), bounded by budget
    task automatic wait_done(input int min_cyc, input int budget);
        int n = 0;
        while ((n < min_cyc || wq.size() != 0 || fq.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_timeout", 32'(wq.size() + fq.size()), 32'd0);
        wq.delete();
        fq.delete();
    endtask

    initial begin
        vec_t vecs[11];
        reset = 1'b1;
        vecs[0]  = '{enc_r(1, 2, 16, 6'h20), 32'd5,         32'd19,        32'd24,        1'b0};
        vecs[1]  = '{enc_r(1, 2, 16, 6'h20), 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b1};
        vecs[2]  = '{enc_r(1, 2, 16, 6'h22), 32'd10,        32'd3,         32'd7,         1'b0};
        vecs[3]  = '{enc_r(1, 2, 16, 6'h22), 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{enc_r(1, 2, 16, 6'h22), 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1};
        vecs[5]  = '{enc_r(1, 2, 16, 6'h2A), 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
        vecs[6]  = '{enc_r(1, 2, 16, 6'h2A), 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[7]  = '{enc_r(1, 2, 16, 6'h2A), 32'd5,         32'd5,         32'd0,         1'b0};
        vecs[8]  = '{enc_i(6'h08, 1, 16, 16'h0001), 32'h7FFF_FFFF, 32'd0,  32'h8000_0000, 1'b1};
        vecs[9]  = '{enc_i(6'h08, 1, 16, 16'hFFFF), 32'd10,        32'd0,  32'd9,         1'b0};
        vecs[10] = '{enc_i(6'h0E, 1, 16, 16'h8001), 32'hFFFF_0000, 32'd0,  32'hFFFF_8001, 1'b0};

        // ALU vectors: operands loaded with lw, result stored with sw and read from s0
        for (int i = 0; i < 11; i++) begin
            do_reset();
            ack_delay = i % 3;
            mem[0] = enc_i(6'h23, 0, 1, 16'h0200);
            mem[1] = enc_i(6'h23, 0, 2, 16'h0204);
            mem[2] = vecs[i].insn;
            mem[3] = enc_i(6'h2B, 0, 16, 16'h0208);
            mem[4] = enc_j(6'h02, 26'h4);
            mem[16'h80] = vecs[i].a;
            mem[16'h81] = vecs[i].b;
`ifdef MULTICYCLE_CPU_OVF_TRAP_EN
            if (vecs[i].ovf) begin
                release_reset();
                wait_done(40, 200);
                chk($sformatf("vec%0d_trap", i), 32'(trap), 32'd1);
                chk($sformatf("vec%0d_state", i), 32'(state), 32'd5);
                chk($sformatf("vec%0d_s0_kept", i), s0, 32'h0);
                continue;
            end
`endif
            wq.push_back('{16'h0208, vecs[i].exp});
            release_reset();
            wait_done(0, 200);
            chk($sformatf("vec%0d_s0", i), s0, vecs[i].exp);
            chk($sformatf("vec%0d_trap", i), 32'(trap), 32'd0);
        end

        // Three ALU ops with same-cycle ack: s0 lands after exactly 12 cycles
        do_reset();
        mem[0] = enc_i(6'h08, 0, 17, 16'd5);
        mem[1] = enc_i(6'h08, 0, 18, 16'd19);
        mem[2] = enc_r(17, 18, 16, 6'h20);
        mem[3] = enc_j(6'h02, 26'h3);
        release_reset();
        #1;
        chk("first_fetch_req", 32'(bus_if.mem_req), 32'd1);
        chk("first_fetch_addr", 32'(bus_if.mem_addr), 32'h0);
        repeat (11) @(posedge clk);
        #1;
        chk("s0_at_11", s0, 32'd0);
        @(posedge clk);
        #1;
        chk("s0_at_12", s0, 32'd24);
        chk("state_at_12", 32'(state), 32'd0);
        chk("pc_at_12", 32'(pc), 32'hC);

        // sw then lw through 0x40 with 3 wait cycles per transfer
        do_reset();
        ack_delay = 3;
        mem[0] = enc_i(6'h08, 0, 16, 16'd24);
        mem[1] = enc_i(6'h2B, 0, 16, 16'h0040);
        mem[2] = enc_i(6'h23, 0, 19, 16'h0040);
        mem[3] = enc_i(6'h2B, 0, 19, 16'h0044);
        mem[4] = enc_j(6'h02, 26'h4);
        wq.push_back('{16'h0040, 32'd24});
        wq.push_back('{16'h0044, 32'd24});
        release_reset();
        repeat (6) @(posedge clk);
        #1;
        chk("wait_lat_state6", 32'(state), 32'd4);
        @(posedge clk);
        #1;
        chk("wait_lat_state7", 32'(state), 32'd0);
        chk("wait_lat_pc7", 32'(pc), 32'h4);
        wait_done(0, 300);
        chk("one_write_at_40", 32'(n_wr40), 32'd1);

        // jal 0x100 from 0x8, store r31, jr r31 back to 0xC
        do_reset();
        mem[0]     = enc_i(6'h08, 0, 5, 16'd7);
        mem[1]     = enc_i(6'h08, 0, 6, 16'd1);
        mem[2]     = enc_j(6'h03, 26'h40);
        mem[16'h40] = enc_i(6'h2B, 0, 31, 16'h0048);
        mem[16'h41] = enc_r(31, 0, 0, 6'h08);
        mem[3]     = enc_i(6'h2B, 0, 5, 16'h004C);
        mem[4]     = enc_j(6'h02, 26'h4);
        foreach (fq[k]) fq.delete(k);
        fq = '{16'h0000, 16'h0004, 16'h0008, 16'h0100, 16'h0104, 16'h000C, 16'h0010};
        wq.push_back('{16'h0048, 32'h0000_000C});
        wq.push_back('{16'h004C, 32'd7});
        release_reset();
        wait_done(0, 200);

        // bne not taken when equal, taken backwards (-2) when different
        do_reset();
        mem[0] = enc_i(6'h08, 0, 1, 16'd3);
        mem[1] = enc_i(6'h08, 0, 2, 16'd3);
        mem[2] = enc_i(6'h05, 1, 2, 16'd5);
        mem[3] = enc_i(6'h08, 0, 2, 16'd4);
        mem[4] = enc_i(6'h05, 1, 2, 16'hFFFE);
        fq = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h000C};
        release_reset();
        wait_done(0, 200);

        // bne taken at pc 0 wraps to 0xFFFC
        do_reset();
        mem[0]        = enc_i(6'h05, 1, 2, 16'hFFFE);
        mem[1]        = enc_i(6'h08, 0, 1, 16'd1);
        mem[2]        = enc_j(6'h02, 26'h0);
        mem[16'h3FFF] = enc_j(6'h02, 26'h8);
        mem[8]        = enc_i(6'h2B, 0, 1, 16'h0050);
        mem[9]        = enc_j(6'h02, 26'h9);
        fq = '{16'h0000, 16'h0004, 16'h0008, 16'h0000, 16'hFFFC, 16'h0020, 16'h0024};
        wq.push_back('{16'h0050, 32'd1});
        release_reset();
        wait_done(0, 200);

        // Illegal opcode 0x3F traps and stops requesting
        do_reset();
        mem[0] = 32'hFC00_0000;
        fq.push_back(16'h0000);
        release_reset();
        wait_done(20, 100);
        chk("illegal_trap", 32'(trap), 32'd1);
        chk("illegal_state", 32'(state), 32'd5);
        chk("illegal_pc", 32'(pc), 32'h4);
        chk("illegal_inst", inst, 32'hFC00_0000);
        chk("illegal_no_req", 32'(bus_if.mem_req), 32'd0);

        // Reset mid-fetch with an ack arriving while reset is held
        do_reset();
        mem[0] = enc_i(6'h08, 0, 16, 16'h0055);
        mem[1] = enc_i(6'h2B, 0, 16, 16'h0060);
        mem[2] = enc_j(6'h02, 26'h2);
        mem_auto = 1'b0;
        man_ack = 1'b0;
        release_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        man_ack = 1'b1;
        man_rdata = 32'hFC00_0000;
        #2;
        chk("abort_req_low", 32'(bus_if.mem_req), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        man_ack = 1'b0;
        reset = 1'b0;
        mem_auto = 1'b1;
        #2;
        chk("abort_pc", 32'(pc), 32'h0);
        chk("abort_trap", 32'(trap), 32'd0);
        chk("abort_inst", inst, 32'h0);
        chk("abort_state", 32'(state), 32'd0);
        wq.push_back('{16'h0060, 32'h55});
        wait_done(0, 200);
        chk("abort_resume_s0", s0, 32'h55);
        chk("abort_resume_trap", 32'(trap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
